fft_frame_scheduler: RTL and testbench

Shares a single fft_processor instance between NUM_CH independent IQ sample channels at frame granularity. Round-robin arbitration picks one channel per frame. The block then streams exactly FFT_SIZE samples from that channel into the FFT and counts FFT_SIZE fft_valid outputs. Each output bin is tagged with its source channel, and one completion/status pulse is issued per frame. It sits between the per-channel decimator outputs and the fft_processor.

---
 rtl/fft_frame_scheduler.sv | 162 ++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// Frame-granular round-robin scheduler sharing one fft_processor between NUM_CH IQ channels.
// Optional per-channel overflow statistics are enabled by defining FFT_SCHED_STATS_EN.
module fft_frame_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int FFT_SIZE       = 256,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_real_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_imag_in,
  input  logic [NUM_CH-1:0]              ch_valid,
  output logic [NUM_CH-1:0]              ch_ready,
  output logic [DATA_WIDTH-1:0]          fft_real_in,
  output logic [DATA_WIDTH-1:0]          fft_imag_in,
  output logic                           fft_data_valid,
  input  logic                           fft_valid,
  input  logic                           overflow_flag,
  input  logic                           processing_active,
  output logic [$clog2(NUM_CH)-1:0]      out_channel,
  output logic                           frame_done,
  output logic                           frame_overflow,
  output logic                           frame_timeout,
  output logic [15:0]                    frame_count,
  output logic                           busy
`ifdef FFT_SCHED_STATS_EN
  ,
  input  logic                           stat_clr,
  output logic [NUM_CH*16-1:0]           stat_ovf_frames
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FFT_SIZE) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_SIZE - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_OUT, DONE} state_t;

  state_t            state, next_state;
  logic [CH_W-1:0]   rr_ptr, grant, pick;
  logic              pick_found;
  logic [CNT_W-1:0]  load_cnt, out_cnt;
  logic [WD_W-1:0]   watchdog;
  logic              ovf_sticky, timeout;
  logic              xfer, load_last, out_last, wd_expired, start;
  int unsigned       idx;

  // First valid channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick       = rr_ptr;
    pick_found = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!pick_found && ch_valid[CH_W'(idx)]) begin
        pick_found = 1'b1;
        pick       = CH_W'(idx);
      end
    end
  end

  assign start      = (state == IDLE) && pick_found && !processing_active;
  assign xfer       = (state == LOAD) && ch_valid[grant];
  assign load_last  = xfer && (load_cnt == LAST_IDX);
  assign out_last   = fft_valid && (out_cnt == LAST_IDX);
  assign wd_expired = (watchdog == WD_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (start) next_state = LOAD;
      LOAD:     if (load_last) next_state = WAIT_OUT;
      WAIT_OUT: if (out_last || wd_expired) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Ready is decoded from state so it falls on the same edge that leaves LOAD.
  always_comb begin
    ch_ready       = '0;
    if (state == LOAD) ch_ready = NUM_CH'(1) << grant;
    busy           = (state != IDLE);
    frame_done     = (state == DONE);
    frame_overflow = frame_done && ovf_sticky;
    frame_timeout  = frame_done && timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_real_in    <= '0;
      fft_imag_in    <= '0;
      fft_data_valid <= 1'b0;
      out_channel    <= '0;
      frame_count    <= '0;
      rr_ptr         <= '0;
      grant          <= '0;
      load_cnt       <= '0;
      out_cnt        <= '0;
      watchdog       <= '0;
      ovf_sticky     <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      fft_data_valid <= xfer;
      if (xfer) begin
        fft_real_in <= ch_real_in[grant*DATA_WIDTH +: DATA_WIDTH];
        fft_imag_in <= ch_imag_in[grant*DATA_WIDTH +: DATA_WIDTH];
        load_cnt    <= load_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            grant       <= pick;
            out_channel <= pick;
            load_cnt    <= '0;
            out_cnt     <= '0;
            watchdog    <= '0;
            ovf_sticky  <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        LOAD: ovf_sticky <= ovf_sticky | overflow_flag;
        WAIT_OUT: begin
          ovf_sticky <= ovf_sticky | overflow_flag;
          watchdog   <= watchdog + 1'b1;
          if (fft_valid) out_cnt <= out_cnt + 1'b1;
          // A frame whose last bin lands on the expiry cycle still counts as complete.
          if (wd_expired && !out_last) timeout <= 1'b1;
        end
        DONE: begin
          frame_count <= frame_count + 1'b1;
          rr_ptr      <= (grant == LAST_CH) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ovf_frames <= '0;
    end else if (stat_clr) begin
      stat_ovf_frames <= '0;
    end else if (frame_overflow && (stat_ovf_frames[grant*16 +: 16] != 16'hFFFF)) begin
      stat_ovf_frames[grant*16 +: 16] <= stat_ovf_frames[grant*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: randomized frames against a frame-level reference model.
module tb_fft_frame_scheduler;
  localparam int NUM_CH  = 4;
  localparam int FFT_SIZE = 16;
  localparam int DW      = 24;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_CH*DW-1:0]   ch_real_in, ch_imag_in;
  logic [NUM_CH-1:0]      ch_valid, ch_ready;
  logic [DW-1:0]          fft_real_in, fft_imag_in;
  logic                   fft_data_valid, fft_valid, overflow_flag, processing_active;
  logic [1:0]             out_channel;
  logic                   frame_done, frame_overflow, frame_timeout, busy;
  logic [15:0]            frame_count;
`ifdef FFT_SCHED_STATS_EN
  logic [NUM_CH*16-1:0]   stat_ovf_frames;
`endif

  int checks = 0;
  int errors = 0;
  int rr_model = 0;
  int fc_model = 0;

  always #5 clk = ~clk;

  fft_frame_scheduler #(
    .NUM_CH(NUM_CH), .FFT_SIZE(FFT_SIZE), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_real_in(ch_real_in), .ch_imag_in(ch_imag_in),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .fft_real_in(fft_real_in), .fft_imag_in(fft_imag_in), .fft_data_valid(fft_data_valid),
    .fft_valid(fft_valid), .overflow_flag(overflow_flag), .processing_active(processing_active),
    .out_channel(out_channel), .frame_done(frame_done), .frame_overflow(frame_overflow),
    .frame_timeout(frame_timeout), .frame_count(frame_count), .busy(busy)
`ifdef FFT_SCHED_STATS_EN
    , .stat_clr(1'b0), .stat_ovf_frames(stat_ovf_frames)
`endif
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // mode: 0 normal, 1 grant valid toggling, 2 no fft output (watchdog), 3 reset after 7 transfers
  task automatic run_frame(input logic [NUM_CH-1:0] req_mask, input int mode, input bit ovf,
                           input int hold_busy);
    int exp_g, xfers, cyc, wait_n, pulses, ovf_at;
    logic [NUM_CH-1:0] onehot;
    logic prev_x, v, fv, ovf_m;
    logic [DW-1:0] exp_re, exp_im;

    exp_g = -1;
    for (int i = 0; i < NUM_CH; i++)
      if (exp_g < 0 && req_mask[(rr_model + i) % NUM_CH]) exp_g = (rr_model + i) % NUM_CH;
    onehot = 4'b0001 << exp_g;
    exp_re = '0;
    exp_im = '0;

    @(negedge clk);
    ch_valid          = req_mask;
    processing_active = (hold_busy > 0);
    fft_valid         = 1'b0;
    overflow_flag     = 1'b0;
    for (int k = 0; k < hold_busy; k++) begin
      @(negedge clk);
      check("held_off_ready", ch_ready, 0);
      check("held_off_busy", busy, 0);
    end
    processing_active = 1'b0;

    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (ch_ready == '0 && wait_n < 8);
    check("grant_latency", wait_n, 1);
    check("grant_ready", ch_ready, onehot);
    check("grant_channel", out_channel, exp_g);
    check("busy_load", busy, 1);

    xfers  = 0;
    cyc    = 0;
    prev_x = 1'b0;
    ovf_m  = 1'b0;
    while (xfers < FFT_SIZE && cyc < 200) begin
      check("data_valid", fft_data_valid, prev_x);
      if (prev_x) begin
        check("real_out", fft_real_in, exp_re);
        check("imag_out", fft_imag_in, exp_im);
      end
      check("ready_onehot", ch_ready, onehot);
      if (mode == 3 && xfers == 7) break;
      for (int c = 0; c < NUM_CH; c++) begin
        ch_real_in[c*DW +: DW] = DW'($urandom);
        ch_imag_in[c*DW +: DW] = DW'($urandom);
      end
      v = (mode == 1) ? (cyc % 2 == 0) : ($urandom % 4 != 0);
      ch_valid = NUM_CH'($urandom) & ~onehot;
      if (v) ch_valid = ch_valid | onehot;
      fft_valid = ($urandom % 4 == 0);
      prev_x = v;
      if (v) begin
        exp_re = ch_real_in[exp_g*DW +: DW];
        exp_im = ch_imag_in[exp_g*DW +: DW];
        xfers++;
      end
      cyc++;
      @(negedge clk);
    end

    if (mode == 3) begin
      rst_n = 1'b0;
      #1;
      check("rst_ready", ch_ready, 0);
      check("rst_data_valid", fft_data_valid, 0);
      check("rst_real", fft_real_in, 0);
      check("rst_out_channel", out_channel, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      ch_valid  = '0;
      fft_valid = 1'b0;
      @(negedge clk);
      check("rst_no_done", frame_done, 0);
      rst_n    = 1'b1;
      rr_model = 0;
      fc_model = 0;
      return;
    end

    if (xfers != FFT_SIZE) check("load_bound", xfers, FFT_SIZE);
    check("data_valid_last", fft_data_valid, 1);
    check("real_last", fft_real_in, exp_re);
    check("imag_last", fft_imag_in, exp_im);
    check("ready_drop", ch_ready, 0);
    check("busy_wait", busy, 1);
    ch_valid = onehot;

    if (mode == 2) begin
      fft_valid     = 1'b0;
      overflow_flag = 1'b0;
      for (int k = 1; k < TIMEOUT; k++) begin
        @(negedge clk);
        if (k == 1) check("no_extra_sample", fft_data_valid, 0);
        check("early_timeout", frame_done, 0);
      end
      @(negedge clk);
      check("timeout_done", frame_done, 1);
      check("timeout_flag", frame_timeout, 1);
      check("timeout_ovf", frame_overflow, 0);
      check("timeout_channel", out_channel, exp_g);
    end else begin
      ovf_at = $urandom % FFT_SIZE;
      pulses = 0;
      cyc    = 0;
      while (pulses < FFT_SIZE) begin
        fv            = ($urandom % 2 == 1) || (cyc >= 30);
        fft_valid     = fv;
        overflow_flag = ovf && fv && (pulses == ovf_at);
        if (overflow_flag) ovf_m = 1'b1;
        if (fv) pulses++;
        cyc++;
        @(negedge clk);
        if (cyc == 1) check("no_extra_sample", fft_data_valid, 0);
        if (pulses < FFT_SIZE) check("early_done", frame_done, 0);
      end
      fft_valid     = 1'b0;
      overflow_flag = 1'b0;
      check("frame_done", frame_done, 1);
      check("frame_overflow", frame_overflow, ovf_m);
      check("frame_timeout", frame_timeout, 0);
      check("done_channel", out_channel, exp_g);
    end

    ch_valid  = '0;
    fft_valid = 1'b0;
    rr_model  = (exp_g + 1) % NUM_CH;
    fc_model  = (fc_model + 1) % 65536;
    @(negedge clk);
    check("frame_count", frame_count, fc_model);
    check("done_one_cycle", frame_done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n             = 1'b1;
    ch_valid          = '0;
    ch_real_in        = '0;
    ch_imag_in        = '0;
    fft_valid         = 1'b0;
    overflow_flag     = 1'b0;
    processing_active = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_ready", ch_ready, 0);
    check("reset_data_valid", fft_data_valid, 0);
    check("reset_out_channel", out_channel, 0);
    check("reset_frame_count", frame_count, 0);
    check("reset_done", frame_done, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(4'b0100, 0, 1'b0, 0);
    check("count_after_first", frame_count, 1);
    run_frame(4'b1111, 3, 1'b0, 0);
    for (int f = 0; f < 8; f++) run_frame(4'b1111, 0, (f == 1), (f == 0) ? 3 : 0);
    check("count_after_eight", frame_count, 8);
    run_frame(4'b0010, 1, 1'b0, 0);
    repeat (6) run_frame(NUM_CH'($urandom_range(1, 15)), int'($urandom % 2), bit'($urandom % 2),
                         int'($urandom % 3));
    run_frame(4'b1001, 2, 1'b0, 0);
    run_frame(4'b1111, 0, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
